ifetch_prefetch: RTL and testbench

- Instruction-fetch front end. Sits directly upstream of the RISC-V CPU core's instruction port.
- Generates sequential fetch addresses and issues them to a multi-cycle instruction memory over a req/gnt/rvalid bus.
- Buffers returned words with their PCs in a small FIFO and presents them to the core with a valid/ready handshake.
- Core branch/jump redirects flush the buffer and discard in-flight responses.

---
 rtl/ifetch_prefetch.sv | 116 +++++++++++
 tb/tb_ifetch_prefetch.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/ifetch_prefetch.sv
// Instruction-fetch front end: issues sequential word fetches over a req/gnt/rvalid bus,
// buffers returned words with their PCs, and flushes on core redirects.
module ifetch_prefetch #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         redirect,
    input  logic [31:0]                  redirect_pc,
    output logic                         instr_valid,
    output logic [31:0]                  instr,
    output logic [31:0]                  instr_pc,
    input  logic                         instr_ready,
    output logic                         mem_req,
    output logic [31:0]                  mem_addr,
    input  logic                         mem_gnt,
    input  logic                         mem_rvalid,
    input  logic [31:0]                  mem_rdata,
    output logic [$clog2(DEPTH+1)-1:0]   fifo_count
);

    localparam int            CW      = $clog2(DEPTH + 1);
    localparam int            AW      = $clog2(DEPTH);
    localparam logic [CW:0]   DEPTH_C = (CW + 1)'(DEPTH);

    logic [31:0]   fetch_pc;
    logic [31:0]   resp_pc;
    logic [CW-1:0] inflight;
    logic [CW-1:0] inflight_next;
    logic [CW-1:0] drop_cnt;
    logic [CW-1:0] count;
    logic [AW-1:0] head;
    logic [AW-1:0] tail;
    logic [31:0]   data_q [DEPTH];
    logic [31:0]   pc_q   [DEPTH];

    logic grant;
    logic rsp;
    logic push;
    logic pop;

    // Credit rule: buffered plus outstanding words never exceed the FIFO capacity.
    assign mem_req  = !reset && !redirect && (({1'b0, count} + {1'b0, inflight}) < DEPTH_C);
    assign mem_addr = fetch_pc;
    assign grant    = mem_req && mem_gnt;

    // A response with nothing outstanding is a protocol violation and is ignored.
    assign rsp  = !reset && mem_rvalid && (inflight != '0);
    assign push = rsp && !redirect && (drop_cnt == '0);
    assign pop  = !reset && !redirect && instr_valid && instr_ready;

    always_comb begin
        // NOTE: default assignment first so no path leaves inflight_next unassigned (no latch).
        inflight_next = inflight;
        if (grant && !rsp)
            inflight_next = inflight + CW'(1);
        else if (!grant && rsp)
            inflight_next = inflight - CW'(1);
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments throughout sequential logic so every register
        // samples pre-edge values regardless of statement order.
        if (reset) begin
            fetch_pc <= RESET_PC;
            resp_pc  <= RESET_PC;
            inflight <= '0;
            drop_cnt <= '0;
            count    <= '0;
            head     <= '0;
            tail     <= '0;
        end else if (redirect) begin
            fetch_pc <= {redirect_pc[31:2], 2'b00};
            resp_pc  <= {redirect_pc[31:2], 2'b00};
            inflight <= inflight_next;
            drop_cnt <= inflight_next;
            count    <= '0;
            head     <= '0;
            tail     <= '0;
        end else begin
            inflight <= inflight_next;
            if (grant)
                fetch_pc <= fetch_pc + 32'd4;
            if (rsp) begin
                if (drop_cnt != '0)
                    drop_cnt <= drop_cnt - CW'(1);
                else
                    resp_pc <= resp_pc + 32'd4;
            end
            if (push)
                tail <= tail + AW'(1);
            if (pop)
                head <= head + AW'(1);
            if (push && !pop)
                count <= count + CW'(1);
            else if (!push && pop)
                count <= count - CW'(1);
        end
    end

    // NOTE: FIFO storage is deliberately not reset; entries are only read once count
    // says they were written, and the output mux forces zeros while empty.
    always_ff @(posedge clk) begin
        if (push) begin
            data_q[tail] <= mem_rdata;
            pc_q[tail]   <= resp_pc;
        end
    end

    assign instr_valid = (count != '0);
    assign instr       = instr_valid ? data_q[head] : 32'h0;
    assign instr_pc    = instr_valid ? pc_q[head]   : 32'h0;
    assign fifo_count  = count;

endmodule

// File: tb/tb_ifetch_prefetch.sv
// Randomized bench for ifetch_prefetch: a latency-randomizing memory model plus a
// PC-stream reference (sequential PCs from each reset/redirect target, data = hash(pc)).
module tb_ifetch_prefetch;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic [2:0]  fifo_count;

    ifetch_prefetch #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk         (clk),
        .reset       (reset),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_ready (instr_ready),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_gnt     (mem_gnt),
        .mem_rvalid  (mem_rvalid),
        .mem_rdata   (mem_rdata),
        .fifo_count  (fifo_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          epoch;
        int          due;
    } req_t;

    req_t        pend[$];
    int          epoch;
    int          cyc;
    int          last_due;
    int          model_count;
    logic [31:0] exp_fetch;
    logic [31:0] exp_out;
    bit          after_reset;
    int          lat_lo = 1;
    int          lat_hi = 1;
    int          vectors;
    int          miscompares;

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s @cyc %0d: got %h expected %h", tag, cyc, got, exp);
        end
    endtask

    // One clock cycle: drive inputs, check outputs against the model, advance the model.
    task automatic step(input bit rst, input bit redir, input logic [31:0] rpc,
                        input bit ready, input bit gnt);
        bit   rv;
        bit   exp_req;
        bit   live;
        req_t r;
        int   due;
        @(negedge clk);
        rv = !rst && (pend.size() > 0) && (pend[0].due <= cyc);
        reset       = rst;
        redirect    = redir;
        redirect_pc = rpc;
        instr_ready = ready;
        mem_gnt     = gnt;
        mem_rvalid  = rv;
        mem_rdata   = rv ? word_of(pend[0].addr) : $urandom;
        #1;
        exp_req = !rst && !redir && (model_count + pend.size() < DEPTH);
        check("mem_req", {31'b0, mem_req}, {31'b0, exp_req});
        if (!rst) begin
            check("fifo_count", {29'b0, fifo_count}, model_count);
            check("instr_valid", {31'b0, instr_valid}, {31'b0, model_count != 0});
            if (model_count != 0) begin
                check("instr_pc", instr_pc, exp_out);
                check("instr", instr, word_of(exp_out));
            end
            if (exp_req)
                check("mem_addr", mem_addr, exp_fetch);
            if (after_reset) begin
                check("rst_instr", instr, 32'h0);
                check("rst_instr_pc", instr_pc, 32'h0);
            end
        end

        if (rst) begin
            pend.delete();
            model_count = 0;
            exp_fetch   = RESET_PC;
            exp_out     = RESET_PC;
            epoch++;
            last_due    = 0;
            after_reset = 1'b1;
        end else begin
            after_reset = 1'b0;
            live = 1'b0;
            if (rv) begin
                live = (pend[0].epoch == epoch);
                void'(pend.pop_front());
            end
            if (redir) begin
                epoch++;
                model_count = 0;
                exp_fetch   = {rpc[31:2], 2'b00};
                exp_out     = {rpc[31:2], 2'b00};
            end else begin
                if (model_count != 0 && ready) begin
                    model_count--;
                    exp_out += 32'd4;
                end
                if (live)
                    model_count++;
                if (exp_req && gnt) begin
                    due = cyc + $urandom_range(lat_hi, lat_lo);
                    if (due < last_due)
                        due = last_due;
                    last_due = due;
                    r.addr  = exp_fetch;
                    r.epoch = epoch;
                    r.due   = due;
                    pend.push_back(r);
                    exp_fetch += 32'd4;
                end
            end
        end
        cyc++;
    endtask

    initial begin
        reset = 1'b1; redirect = 1'b0; redirect_pc = '0; instr_ready = 1'b0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;

        repeat (2) step(1, 0, 0, 0, 0);

        // Straight-line fetch, 1-cycle memory.
        repeat (12) step(0, 0, 0, 1, 1);

        // Backpressure: fill to DEPTH, then drain.
        repeat (10) step(0, 0, 0, 0, 1);
        check("bp_full", {29'b0, fifo_count}, DEPTH);
        repeat (12) step(0, 0, 0, 1, 1);

        // Redirect with requests outstanding on a 3-cycle memory.
        lat_lo = 3; lat_hi = 3;
        repeat (4) step(0, 0, 0, 1, 1);
        step(0, 1, 32'h0000_0100, 1, 1);
        repeat (12) step(0, 0, 0, 1, 1);

        // Back-to-back redirects with stale responses pending.
        repeat (3) step(0, 0, 0, 1, 1);
        step(0, 1, 32'h0000_0200, 1, 1);
        step(0, 1, 32'h0000_0303, 1, 1);
        repeat (12) step(0, 0, 0, 1, 1);

        // Grant stall, then wrap across the top of the address space.
        lat_lo = 1; lat_hi = 1;
        repeat (5) step(0, 0, 0, 1, 0);
        step(0, 1, 32'hFFFF_FFFC, 1, 1);
        repeat (10) step(0, 0, 0, 1, 1);

        // Reset mid-operation with buffered and in-flight words.
        lat_lo = 2; lat_hi = 2;
        repeat (4) step(0, 0, 0, 0, 1);
        step(1, 0, 0, 0, 1);
        repeat (10) step(0, 0, 0, 1, 1);

        // Randomized traffic.
        lat_lo = 1; lat_hi = 4;
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(199, 0) == 0),
                 ($urandom_range(29, 0) == 0),
                 $urandom,
                 ($urandom_range(9, 0) < 7),
                 ($urandom_range(9, 0) < 7));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
